// File: rtl/vga_dla_if.sv
// Control inputs, SRAM address/strobe bus and VGA output bus of the vga_dla engine.
// The bidirectional SRAM data bus stays a plain port on the module.
interface vga_dla_if;
    logic        clear;
    logic        run;
    logic [19:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic        vga_sync;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    modport master (
        input  clear, run,
        output sram_addr, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n,
        output vga_hs, vga_vs, vga_blank, vga_sync, vga_r, vga_g, vga_b
    );

    modport slave (
        output clear, run,
        input  sram_addr, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n,
        input  vga_hs, vga_vs, vga_blank, vga_sync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_dla.sv
// DLA engine with 640x480@60 VGA timing; the walker runs only during sync intervals.
// Define DLA_LED_EN to add the ledr/ledg status outputs.
module vga_dla #(
    parameter logic [15:0] FG      = 16'hFFFF,
    parameter logic [30:0] XR_SEED = 31'h55555555,
    parameter logic [28:0] YR_SEED = 29'h15555555,
    parameter logic [9:0]  WX0     = 10'd155,
    parameter logic [9:0]  WY0     = 10'd120
) (
    input  logic       clk,
    input  logic       rst,
    vga_dla_if.master  bus,
    inout  wire [15:0] sram_dq
`ifdef DLA_LED_EN
    ,
    output logic [17:0] ledr,
    output logic [8:0]  ledg
`endif
);

    typedef enum logic [3:0] {
        StInit, StTest1, StTest2, StTest3, StTest4, StTest5, StTest6,
        StDraw, StUpdate, StNew
    } state_e;

    logic [9:0]  x_q, y_q, x_d, y_d;
    logic        hs_n, vs_n, blank, step;
    state_e      state_q;
    logic [19:0] addr_q;
    logic        we_n_q, lock_q;
    logic [15:0] data_q;
    logic [30:0] xr_q;
    logic [28:0] yr_q;
    logic [9:0]  xw_q, yw_q;
    logic [3:0]  sum_q;
    logic        unused_dq;

    always_comb begin
        x_d = x_q + 10'd1;
        y_d = y_q;
        if (x_q == 10'd799) begin
            x_d = 10'd0;
            y_d = (y_q == 10'd524) ? 10'd0 : y_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= 10'd0;
            y_q <= 10'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign hs_n  = !(x_q >= 10'd656 && x_q <= 10'd751);
    assign vs_n  = !(y_q >= 10'd490 && y_q <= 10'd491);
    assign blank = (x_q < 10'd640) && (y_q < 10'd480);
    assign step  = (!hs_n || !vs_n) && bus.run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            addr_q  <= '0;
            we_n_q  <= 1'b1;
            data_q  <= '0;
            xr_q    <= XR_SEED;
            yr_q    <= YR_SEED;
            xw_q    <= WX0;
            yw_q    <= WY0;
            lock_q  <= 1'b0;
            sum_q   <= '0;
`ifdef DLA_LED_EN
            ledr    <= '0;
            ledg    <= '0;
`endif
        end else if (bus.clear) begin
            state_q <= StInit;
            addr_q  <= {x_q, y_q};
            we_n_q  <= 1'b1;
            data_q  <= '0;
            xr_q    <= XR_SEED;
            yr_q    <= YR_SEED;
            xw_q    <= WX0;
            yw_q    <= WY0;
            lock_q  <= 1'b0;
            sum_q   <= '0;
        end else if (!step) begin
            // Display owns the SRAM; the walker state is held for the next window.
            lock_q <= 1'b0;
            addr_q <= {x_q, y_q};
            we_n_q <= 1'b1;
        end else begin
            case (state_q)
                StInit: begin
                    addr_q  <= {10'd160, 10'd120};
                    we_n_q  <= 1'b0;
                    data_q  <= FG;
                    state_q <= StTest1;
                end
                StTest1: begin
                    lock_q  <= 1'b1;
                    sum_q   <= '0;
                    we_n_q  <= 1'b1;
                    addr_q  <= {xw_q - 10'd1, yw_q};
                    state_q <= StTest2;
                end
                StTest2: begin
                    sum_q   <= sum_q + {3'd0, sram_dq[15]};
                    addr_q  <= {xw_q + 10'd1, yw_q};
                    state_q <= StTest3;
                end
                StTest3: begin
                    sum_q   <= sum_q + {3'd0, sram_dq[15]};
                    addr_q  <= {xw_q, yw_q - 10'd1};
                    state_q <= StTest4;
                end
                StTest4: begin
                    sum_q   <= sum_q + {3'd0, sram_dq[15]};
                    addr_q  <= {xw_q, yw_q + 10'd1};
                    state_q <= StTest5;
                end
                StTest5: begin
                    sum_q   <= sum_q + {3'd0, sram_dq[15]};
                    state_q <= StTest6;
                end
                StTest6: begin
                    // A cleared lock means a window boundary split the reads; sum is stale.
                    if (lock_q && sum_q != 4'd0) begin
                        state_q <= StDraw;
`ifdef DLA_LED_EN
                        ledr    <= {4'b0, xw_q, sum_q};
                        ledg    <= yw_q[8:0];
`endif
                    end else begin
                        state_q <= StUpdate;
`ifdef DLA_LED_EN
                        ledr    <= '0;
                        ledg    <= '0;
`endif
                    end
                end
                StDraw: begin
                    we_n_q  <= 1'b0;
                    addr_q  <= {xw_q, yw_q};
                    data_q  <= FG;
                    state_q <= StNew;
                end
                StUpdate: begin
                    if (xw_q < 10'd318 && xr_q[30]) begin
                        xw_q <= xw_q + 10'd1;
                    end else if (xw_q > 10'd2 && !xr_q[30]) begin
                        xw_q <= xw_q - 10'd1;
                    end
                    if (yw_q < 10'd237 && yr_q[28]) begin
                        yw_q <= yw_q + 10'd1;
                    end else if (yw_q > 10'd2 && !yr_q[28]) begin
                        yw_q <= yw_q - 10'd1;
                    end
                    xr_q    <= {xr_q[29:0], xr_q[27] ^ xr_q[30]};
                    yr_q    <= {yr_q[27:0], yr_q[26] ^ yr_q[28]};
                    state_q <= StTest1;
                end
                StNew: begin
                    xw_q    <= xr_q[30] ? 10'd318 : 10'd2;
                    yw_q    <= yr_q[28] ? 10'd238 : 10'd2;
                    we_n_q  <= 1'b1;
                    xr_q    <= {xr_q[29:0], xr_q[27] ^ xr_q[30]};
                    yr_q    <= {yr_q[27:0], yr_q[26] ^ yr_q[28]};
                    state_q <= StTest1;
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign sram_dq       = we_n_q ? 16'bz : data_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_we_n = we_n_q;
    assign bus.sram_ce_n = 1'b0;
    assign bus.sram_oe_n = 1'b0;
    assign bus.sram_ub_n = 1'b0;
    assign bus.sram_lb_n = 1'b0;

    assign bus.vga_hs    = hs_n;
    assign bus.vga_vs    = vs_n;
    assign bus.vga_blank = blank;
    assign bus.vga_sync  = 1'b0;
    assign bus.vga_r     = blank ? {sram_dq[15:12], 4'b0} : 8'd0;
    assign bus.vga_g     = blank ? {sram_dq[11:8], 4'b0} : 8'd0;
    assign bus.vga_b     = blank ? {sram_dq[7:4], 4'b0} : 8'd0;
    assign unused_dq     = ^sram_dq[3:0];

endmodule

// File: tb/tb_vga_dla.sv
// Scoreboard bench for vga_dla: expected SRAM writes and timed probes are queued up front,
// a negedge monitor pops and compares them against a behavioural async SRAM.
module tb_vga_dla;

    typedef struct packed {
        logic [19:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int          cyc;
        int          kind;
        logic [19:0] val;
        string       name;
    } probe_t;

    localparam int KAddr  = 0;
    localparam int KWe    = 1;
    localparam int KHs    = 2;
    localparam int KVs    = 3;
    localparam int KBlank = 4;
    localparam int KR     = 5;
    localparam int KG     = 6;
    localparam int KB     = 7;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        done = 1'b0;
    int          cyc  = 0;
    int          errs = 0;
    int          checks = 0;
    wire  [15:0] dq;
    logic [15:0] mem [0:1048575];
    wr_t         wr_q[$];
    probe_t      pq[$];
    wr_t         w;
    probe_t      p;
    logic [19:0] act;

    vga_dla_if bus ();

    vga_dla dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sram_dq (dq)
    );

    always #5 clk = ~clk;

    // Async SRAM: combinational read while not writing, write sampled at the clock edge.
    assign dq = bus.sram_we_n ? mem[bus.sram_addr] : 16'bz;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1048576; i++) mem[i] <= '0;
            mem[{10'd154, 10'd120}] <= 16'h8000;
            mem[{10'd100, 10'd0}]   <= 16'hA5C3;
            mem[{10'd645, 10'd0}]   <= 16'hFFFF;
        end else if (!bus.sram_we_n) begin
            mem[bus.sram_addr] <= dq;
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [19:0] xy(input int x, input int y);
        logic [9:0] xs;
        logic [9:0] ys;
        xs = x[9:0];
        ys = y[9:0];
        return {xs, ys};
    endfunction

    function automatic void pp(input int c, input int k, input logic [19:0] v, input string n);
        probe_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.name = n;
        pq.push_back(e);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.sram_we_n == 1'b0) begin
            checks++;
            if (wr_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write (cyc %0d)",
                         bus.sram_addr, dq, cyc);
            end else begin
                w = wr_q.pop_front();
                if (w.addr !== bus.sram_addr || w.data !== dq) begin
                    errs++;
                    $display("FAIL sram_write: got addr=%h data=%h, required addr=%h data=%h",
                             bus.sram_addr, dq, w.addr, w.data);
                end
            end
        end
        while (pq.size() > 0 && pq[0].cyc == cyc) begin
            p = pq.pop_front();
            case (p.kind)
                KAddr:   act = bus.sram_addr;
                KWe:     act = {19'd0, bus.sram_we_n};
                KHs:     act = {19'd0, bus.vga_hs};
                KVs:     act = {19'd0, bus.vga_vs};
                KBlank:  act = {19'd0, bus.vga_blank};
                KR:      act = {12'd0, bus.vga_r};
                KG:      act = {12'd0, bus.vga_g};
                default: act = {12'd0, bus.vga_b};
            endcase
            checks++;
            if (act !== p.val) begin
                errs++;
                $display("FAIL %s (cyc %0d): got %h, required %h", p.name, cyc, act, p.val);
            end
        end
        if (done) begin
            checks++;
            if (wr_q.size() != 0 || pq.size() != 0) begin
                errs++;
                $display("FAIL drain: got %0d writes and %0d probes pending, required 0 and 0",
                         wr_q.size(), pq.size());
            end
            $display("Result: errors=%0d of %0d checks", errs, checks);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    initial begin
        bus.clear = 1'b0;
        bus.run   = 1'b0;

        // Reset state
        pp(0, KAddr, 20'd0, "rst_addr");
        pp(0, KWe, 20'd1, "rst_we_n");
        pp(0, KHs, 20'd1, "rst_hs");
        pp(0, KVs, 20'd1, "rst_vs");
        pp(0, KBlank, 20'd1, "rst_blank");
        // Display readout: visible pixel and a blanked pixel
        pp(101, KAddr, xy(100, 0), "disp_addr");
        pp(101, KR, 20'hA0, "disp_r");
        pp(101, KG, 20'h50, "disp_g");
        pp(101, KB, 20'hC0, "disp_b");
        pp(646, KBlank, 20'd0, "hblank");
        pp(646, KR, 20'h00, "blanked_r");
        pp(655, KHs, 20'd1, "hs_before");
        pp(656, KHs, 20'd0, "hs_start");
        // First window: seed write, neighbour test, stick, respawn, walk
        pp(657, KAddr, xy(160, 120), "init_addr");
        pp(657, KWe, 20'd0, "init_we_n");
        pp(658, KAddr, xy(154, 120), "t1_left");
        pp(658, KWe, 20'd1, "t1_we_n");
        pp(659, KAddr, xy(156, 120), "t2_right");
        pp(660, KAddr, xy(155, 119), "t3_top");
        pp(661, KAddr, xy(155, 121), "t4_bottom");
        pp(663, KAddr, xy(155, 121), "t6_hold");
        pp(664, KAddr, xy(155, 120), "draw_addr");
        pp(664, KWe, 20'd0, "draw_we_n");
        pp(665, KWe, 20'd1, "new_we_n");
        pp(666, KAddr, xy(317, 238), "new_left");
        pp(667, KAddr, xy(319, 238), "new_right");
        pp(668, KAddr, xy(318, 237), "new_top");
        pp(669, KAddr, xy(318, 239), "new_bottom");
        pp(673, KAddr, xy(316, 237), "upd1_walk");
        pp(680, KAddr, xy(317, 237), "upd2_ybound");
        pp(687, KAddr, xy(316, 236), "upd3_walk");
        pp(751, KHs, 20'd0, "hs_end");
        pp(752, KHs, 20'd1, "hs_after");
        pp(753, KAddr, xy(752, 0), "track_addr");
        pp(753, KWe, 20'd1, "track_we_n");
        pp(800, KBlank, 20'd1, "line1_blank");
        pp(800, KVs, 20'd1, "line1_vs");
        // Paused window: address follows the scan
        pp(1500, KAddr, xy(699, 1), "pause_addr");
        pp(1500, KWe, 20'd1, "pause_we_n");
        // After clear: INIT again, window closes after TEST4 with sum=1
        pp(2348, KAddr, xy(160, 120), "clr_init");
        pp(2349, KAddr, xy(154, 120), "clr_left");
        pp(2350, KAddr, xy(156, 120), "clr_right");
        pp(2351, KAddr, xy(155, 119), "clr_top");
        pp(2352, KAddr, xy(155, 121), "clr_bottom");
        pp(2353, KAddr, xy(752, 2), "split_track");
        pp(3060, KAddr, xy(155, 121), "split_update");
        pp(3060, KWe, 20'd1, "split_no_draw");

        wr_q.push_back({xy(160, 120), 16'hFFFF});
        wr_q.push_back({xy(155, 120), 16'hFFFF});
        wr_q.push_back({xy(160, 120), 16'hFFFF});

        repeat (3) @(negedge clk);
        rst     = 1'b0;
        bus.run = 1'b1;
        wait_cyc(753);
        bus.run = 1'b0;
        wait_cyc(1700);
        bus.clear = 1'b1;
        wait_cyc(1701);
        bus.clear = 1'b0;
        wait_cyc(2347);
        bus.run = 1'b1;
        wait_cyc(3060);
        bus.run = 1'b0;
        wait_cyc(3100);
        done = 1'b1;
    end

endmodule
